// File: rtl/trigger_edge_detector_pkg.sv
// Shared trigger-path definitions: detector states, trigger sources, EXT threshold.
package trigger_edge_detector_pkg;

    localparam int unsigned TRIG_DATA_WIDTH = 8;

    // EXT input arrives as {ext_in, 7'b0}; a mid-scale threshold separates 0 from 128.
    localparam logic [TRIG_DATA_WIDTH-1:0] EXT_THRESHOLD = TRIG_DATA_WIDTH'(64);

    typedef enum logic [1:0] {
        ST_WAIT_BELOW = 2'd0,
        ST_ARMED      = 2'd1,
        ST_TRIGGERED  = 2'd2
    } det_state_e;

    typedef enum logic [1:0] {
        SRC_XXX = 2'd0,
        SRC_CH1 = 2'd1,
        SRC_CH2 = 2'd2,
        SRC_EXT = 2'd3
    } trig_src_e;

endpackage

// File: rtl/trigger_edge_detector_if.sv
// Sample stream, threshold and trigger flag between buffer controller and detector.
interface trigger_edge_detector_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] trigger_value;
    logic [DATA_WIDTH-1:0] input_sample;
    logic                  in_ena;
    logic                  triggered;

    modport master (
        output trigger_value,
        output input_sample,
        output in_ena,
        input  triggered
    );

    modport slave (
        input  trigger_value,
        input  input_sample,
        input  in_ena,
        output triggered
    );
endinterface

// File: rtl/trigger_edge_detector.sv
// Rising threshold-crossing detector: needs a below sample, then an at-or-above
// sample, then holds a sticky registered trigger flag until reset.
module trigger_edge_detector
    import trigger_edge_detector_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = TRIG_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    trigger_edge_detector_if.slave   bus
);

    det_state_e            state;
    det_state_e            state_nxt;
    logic                  triggered_q;
    logic                  triggered_nxt;
    logic [DATA_WIDTH-1:0] sample_w;
    logic [DATA_WIDTH-1:0] thresh_w;
    logic                  below;

    assign sample_w = DATA_WIDTH'(bus.input_sample);
    assign thresh_w = DATA_WIDTH'(bus.trigger_value);
    assign below    = (sample_w < thresh_w);

    // State and flag registers; reset returns to waiting for a below sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_WAIT_BELOW;
            triggered_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            triggered_q <= triggered_nxt;
        end
    end

    // Next state; idle cycles (in_ena=0) leave the state untouched.
    always_comb begin
        state_nxt     = state;
        triggered_nxt = 1'b0;
        case (state)
            ST_WAIT_BELOW: begin
                if (bus.in_ena && below) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (bus.in_ena && !below) begin
                    state_nxt = ST_TRIGGERED;
                end
            end
            ST_TRIGGERED: begin
                state_nxt = ST_TRIGGERED;
            end
            default: begin
                state_nxt = ST_WAIT_BELOW;
            end
        endcase
        triggered_nxt = (state_nxt == ST_TRIGGERED);
    end

    assign bus.triggered = triggered_q;

endmodule

// File: tb/tb_trigger_edge_detector.sv
// Scoreboard bench for trigger_edge_detector.
module tb_trigger_edge_detector;
    import trigger_edge_detector_pkg::*;

    localparam int unsigned DW = TRIG_DATA_WIDTH;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic model_armed;
    logic model_trig;
    logic exp_q[$];

    trigger_edge_detector_if #(.DATA_WIDTH(DW)) bus ();

    trigger_edge_detector #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the crossing rule.
    task automatic model_step(input logic ena, input logic [DW-1:0] smp, input logic [DW-1:0] tv);
        if (ena && !model_trig) begin
            if (!model_armed) begin
                if (smp < tv) model_armed = 1'b1;
            end else if (smp >= tv) begin
                model_trig = 1'b1;
            end
        end
    endtask

    // Drive one cycle, push the model's expectation, compare after the edge.
    task automatic step(input string tag, input logic ena, input logic [DW-1:0] smp,
                        input logic [DW-1:0] tv);
        logic e;
        @(negedge clk);
        bus.in_ena        = ena;
        bus.input_sample  = smp;
        bus.trigger_value = tv;
        model_step(ena, smp, tv);
        exp_q.push_back(model_trig);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, int'(bus.triggered), int'(e));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst               = 1'b0;
        bus.in_ena        = 1'b0;
        bus.input_sample  = '0;
        bus.trigger_value = '0;
        model_armed       = 1'b0;
        model_trig        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_flag", int'(bus.triggered), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        errors            = 0;
        checks            = 0;
        rst               = 1'b0;
        bus.in_ena        = 1'b0;
        bus.input_sample  = '0;
        bus.trigger_value = '0;
        model_armed       = 1'b0;
        model_trig        = 1'b0;

        // Basic ramp through threshold 25.
        do_reset();
        step("ramp10", 1'b1, 8'd10, 8'd25);
        step("ramp20", 1'b1, 8'd20, 8'd25);
        check_val("ramp_pre", int'(bus.triggered), 0);
        step("ramp30", 1'b1, 8'd30, 8'd25);
        check_val("ramp_cross", int'(bus.triggered), 1);
        step("ramp40", 1'b1, 8'd40, 8'd25);
        step("ramp_idle", 1'b0, 8'd0, 8'd25);

        // Already above at release must not trigger.
        do_reset();
        step("hi200", 1'b1, 8'd200, 8'd100);
        step("hi150", 1'b1, 8'd150, 8'd100);
        step("arm90", 1'b1, 8'd90, 8'd100);
        step("trig120", 1'b1, 8'd120, 8'd100);
        check_val("trig120_direct", int'(bus.triggered), 1);

        // EXT emulation.
        do_reset();
        step("ext0a", 1'b1, 8'd0, EXT_THRESHOLD);
        step("ext0b", 1'b1, 8'd0, EXT_THRESHOLD);
        step("ext128", 1'b1, 8'd128, EXT_THRESHOLD);
        check_val("ext_trig", int'(bus.triggered), 1);
        do_reset();
        for (int i = 0; i < 3; i++) step("ext_hi_only", 1'b1, 8'd128, EXT_THRESHOLD);
        check_val("ext_hi_only_final", int'(bus.triggered), 0);

        // in_ena gaps ignored; armed state survives the gap.
        do_reset();
        step("gap_arm50", 1'b1, 8'd50, 8'd100);
        for (int i = 0; i < 3; i++) step("gap_idle200", 1'b0, 8'd200, 8'd100);
        check_val("gap_no_trig", int'(bus.triggered), 0);
        step("gap_acc200", 1'b1, 8'd200, 8'd100);
        check_val("gap_trig", int'(bus.triggered), 1);

        // Idle input with unknown sample while ena low.
        do_reset();
        @(negedge clk);
        bus.in_ena       = 1'b0;
        bus.input_sample = 'x;
        @(posedge clk);
        #1;
        check_val("idle_x", int'(bus.triggered), 0);

        // Threshold 0: never arms.
        do_reset();
        for (int i = 0; i < 256; i++) step("tv0_ramp", 1'b1, DW'(i), 8'd0);
        check_val("tv0_final", int'(bus.triggered), 0);

        // Threshold max: triggers only on max value.
        do_reset();
        step("tvmax254", 1'b1, 8'd254, 8'd255);
        step("tvmax254b", 1'b1, 8'd254, 8'd255);
        check_val("tvmax_armed_only", int'(bus.triggered), 0);
        step("tvmax255", 1'b1, 8'd255, 8'd255);
        check_val("tvmax_trig", int'(bus.triggered), 1);

        // Threshold changes per sample: each sample uses its own edge's value.
        do_reset();
        step("tvchg_a", 1'b1, 8'd60, 8'd50);
        step("tvchg_b", 1'b1, 8'd60, 8'd70);
        step("tvchg_c", 1'b1, 8'd60, 8'd55);

        // Async reset while triggered, then no retrigger until a below sample.
        @(posedge clk);
        #3;
        check_val("async_pre", int'(bus.triggered), 1);
        rst         = 1'b0;
        model_armed = 1'b0;
        model_trig  = 1'b0;
        #1;
        check_val("async_drop", int'(bus.triggered), 0);
        @(negedge clk);
        rst = 1'b1;
        step("post150", 1'b1, 8'd150, 8'd100);
        step("post150b", 1'b1, 8'd150, 8'd100);
        check_val("post_no_retrig", int'(bus.triggered), 0);
        step("post50", 1'b1, 8'd50, 8'd100);
        step("post150c", 1'b1, 8'd150, 8'd100);
        check_val("post_retrig", int'(bus.triggered), 1);

        check_val("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
